// File: rtl/encoder_16_4.sv
// 16-line event encoder: latches rising edges on insig and serves them one at a time as a 4-bit index.
// Optional ENCODER_ROUND_ROBIN_EN: rotating-priority selection instead of lowest-index-first.
module encoder_16_4 #(
    parameter int SYNC_STAGES = 2  // legal 0..3; 0 means insig is already synchronous
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] insig,
    output logic [3:0]  outsig,
    output logic        valid,
    input  logic        ready,
    output logic [15:0] pending,
    output logic        drop
);

    logic [15:0] s;
    logic [15:0] hist;
    logic [15:0] rise;
    logic [1:0]  fill_cnt;
    logic        primed;
    logic        load;
    logic        grant;
    logic [3:0]  g;
    logic [3:0]  idx;
    logic [15:0] gbit;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = insig;
        end else begin : g_sync
            logic [15:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
                end else begin
                    sync_q[0] <= insig;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // The sync chain restarts from zero, so hist stays all ones until s carries real
    // line levels again; otherwise lines held high across reset would look like new edges.
    assign primed = (fill_cnt == 2'(SYNC_STAGES));

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= '0;
            hist     <= '1;
        end else begin
            if (!primed) fill_cnt <= fill_cnt + 2'd1;
            if (primed)  hist     <= s;
        end
    end

    assign rise = s & ~hist;
    assign load = !valid || ready;

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [3:0] last_grant;

    always_ff @(posedge clk) begin
        if (rst)        last_grant <= 4'hF;
        else if (grant) last_grant <= g;
    end
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant = 1'b0;
        g     = '0;
        idx   = '0;
        if (load) begin
            for (int i = 0; i < 16; i++) begin
`ifdef ENCODER_ROUND_ROBIN_EN
                idx = last_grant + 4'(i + 1);
`else
                idx = 4'(i);
`endif
                if (!grant && pending[idx]) begin
                    grant = 1'b1;
                    g     = idx;
                end
            end
        end
        gbit = grant ? (16'h0001 << g) : 16'h0000;
    end

    // A rise on a bit being granted this cycle re-arms it, so only ungranted collisions count as drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            outsig  <= '0;
            valid   <= 1'b0;
            pending <= '0;
            drop    <= 1'b0;
        end else begin
            pending <= (pending & ~gbit) | rise;
            drop    <= |(rise & pending & ~gbit);
            if (load) begin
                valid <= grant;
                if (grant) outsig <= g;
            end
        end
    end

endmodule

// File: tb/tb_encoder_16_4.sv
// Directed bench for encoder_16_4 (SYNC_STAGES=2): expected indices go into a scoreboard
// queue when stimulus is driven and are popped on every valid && ready transfer.
module tb_encoder_16_4;

    logic        clk;
    logic        rst;
    logic [15:0] insig;
    logic [3:0]  outsig;
    logic        valid;
    logic        ready;
    logic [15:0] pending;
    logic        drop;

    int errors = 0;
    int checks = 0;
    int drop_count = 0;
    logic [3:0] exp_q [$];
    logic [3:0] first_idx;

    encoder_16_4 #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .insig   (insig),
        .outsig  (outsig),
        .valid   (valid),
        .ready   (ready),
        .pending (pending),
        .drop    (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe transfers and drop pulses mid-cycle, then advance past the next rising edge.
    task automatic tick();
        logic [3:0] exp_idx;
        @(negedge clk);
        if (drop) drop_count++;
        if (valid && ready) begin
            check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_idx = exp_q.pop_front();
                check("xfer_idx", 32'(outsig), 32'(exp_idx));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst   = 1'b1;
        insig = 16'h0005;
        ready = 1'b0;
        ticks(3);
        check("rst_valid",   32'(valid),   32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_outsig",  32'(outsig),  32'd0);
        check("rst_drop",    32'(drop),    32'd0);

        // Lines already high at reset release must not create events.
        rst   = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("held_high_valid",   32'(valid),   32'd0);
            check("held_high_pending", 32'(pending), 32'd0);
        end
        insig = 16'h0000;
        ticks(5);
        check("falling_ignored", 32'(pending), 32'd0);

        // Single event latency: pending after edge k+2, valid after k+3.
        insig = 16'h0100;
        exp_q.push_back(4'd8);
        tick();
        check("lat_k0_pending", 32'(pending), 32'd0);
        tick();
        check("lat_k1_pending", 32'(pending), 32'd0);
        tick();
        check("lat_k2_pending", 32'(pending), 32'h0100);
        check("lat_k2_valid",   32'(valid),   32'd0);
        tick();
        check("lat_k3_valid",   32'(valid),   32'd1);
        check("lat_k3_outsig",  32'(outsig),  32'd8);
        tick();
        check("lat_k4_valid",   32'(valid),   32'd0);
        check("lat_k4_queue",   32'(exp_q.size()), 32'd0);
        insig = 16'h0000;
        ticks(4);
        check("no_drop_single", 32'(drop_count), 32'd0);

`ifdef ENCODER_ROUND_ROBIN_EN
        // Leave last_grant at 5 so the next search begins at 6.
        insig = 16'h0020;
        exp_q.push_back(4'd5);
        ticks(6);
        insig = 16'h0000;
        ticks(3);
        first_idx = 4'd7;
        exp_q.push_back(4'd7);
        exp_q.push_back(4'd12);
        exp_q.push_back(4'd3);
`else
        first_idx = 4'd3;
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd7);
        exp_q.push_back(4'd12);
`endif

        // Simultaneous rises on 3, 7, 12 while the consumer stalls.
        ready = 1'b0;
        insig = 16'h1088;
        ticks(3);
        check("multi_pending_all", 32'(pending), 32'h1088);
        check("multi_valid_pre",   32'(valid),   32'd0);
        tick();
        check("multi_first_out",   32'(outsig),  32'(first_idx));
        ticks(6);
        check("multi_hold_valid",  32'(valid),   32'd1);
        check("multi_hold_out",    32'(outsig),  32'(first_idx));
        check("multi_hold_pend",   32'(pending), 32'(16'h1088 & ~(16'h0001 << first_idx)));
        ready = 1'b1;
        ticks(4);
        check("multi_drained_valid", 32'(valid),        32'd0);
        check("multi_drained_queue", 32'(exp_q.size()), 32'd0);
        insig = 16'h0000;
        ticks(3);

        // Bit 4 fires twice while already pending behind a stalled bit 1.
        ready = 1'b0;
        insig = 16'h0002;
        exp_q.push_back(4'd1);
        tick();
        insig = 16'h0000;
        ticks(4);
        insig = 16'h0010;
        exp_q.push_back(4'd4);
        tick();
        insig = 16'h0000;
        ticks(3);
        check("dup_pending", 32'(pending), 32'h0010);
        check("dup_outsig",  32'(outsig),  32'd1);
        insig = 16'h0010;
        tick();
        insig = 16'h0000;
        ticks(4);
        check("dup_drop_once", 32'(drop_count), 32'd1);
        check("dup_pending2",  32'(pending),    32'h0010);
        ready = 1'b1;
        ticks(4);
        check("dup_drained_valid", 32'(valid),        32'd0);
        check("dup_drained_queue", 32'(exp_q.size()), 32'd0);

        // ready toggles 1,0,1 with two events pending.
        ready = 1'b0;
        insig = 16'h0003;
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        ticks(4);
        check("tog_first_valid", 32'(valid),  32'd1);
        check("tog_first_out",   32'(outsig), 32'd0);
        ready = 1'b1;
        tick();
        check("tog_second_valid", 32'(valid),  32'd1);
        check("tog_second_out",   32'(outsig), 32'd1);
        ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("tog_hold_valid", 32'(valid),  32'd1);
            check("tog_hold_out",   32'(outsig), 32'd1);
        end
        ready = 1'b1;
        tick();
        check("tog_empty_valid",  32'(valid),        32'd0);
        check("tog_keep_outsig",  32'(outsig),       32'd1);
        check("tog_queue",        32'(exp_q.size()), 32'd0);
        insig = 16'h0000;
        ticks(3);

        // Reset while an event is presented and others are pending.
        ready = 1'b0;
        insig = 16'h0004;
        tick();
        insig = 16'h0000;
        ticks(4);
        insig = 16'h00F0;
        ticks(3);
        check("prerst_valid",   32'(valid),   32'd1);
        check("prerst_outsig",  32'(outsig),  32'd2);
        check("prerst_pending", 32'(pending), 32'h00F0);
        rst = 1'b1;
        tick();
        check("midrst_valid",   32'(valid),   32'd0);
        check("midrst_pending", 32'(pending), 32'd0);
        check("midrst_outsig",  32'(outsig),  32'd0);
        check("midrst_drop",    32'(drop),    32'd0);
        rst   = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("postrst_valid",   32'(valid),   32'd0);
            check("postrst_pending", 32'(pending), 32'd0);
        end
        insig = 16'h0000;
        ticks(3);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        check("final_drops", 32'(drop_count),   32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
